timer_555: RTL and testbench

Parametrised 555-timer emulator for the analog sound and video-timing paths. It supports astable and monostable modes, selected at run time. HIGH and LOW phase lengths are set at run time in units of a count-enable strobe. Monostable mode adds optional retriggering and a post-pulse holdoff. It replaces fixed-count astable instances wherever a timer needs programmable lengths, trigger-driven one-shots, or a prescaled time base.

---
 rtl/timer_555.sv | 95 +++++++++
 tb/tb_timer_555.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/timer_555.sv
// timer_555: run-time programmable 555 emulator with astable and monostable modes.
// A single up-counter times both phases against a length latched at phase entry.
module timer_555 #(
  parameter int WIDTH     = 16,
  parameter bit RETRIGGER = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             CE,
  input  logic             ENABLE,
  input  logic             MODE,
  input  logic             TRIG,
  input  logic [WIDTH-1:0] HIGH_COUNT,
  input  logic [WIDTH-1:0] LOW_COUNT,
  output logic             OUT,
  output logic             CYCLE_END
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_len;
  logic             r_trig_d;
  logic             r_out;
  logic             r_cycle_end;
  logic             w_edge;
  logic             w_end;
  logic [WIDTH-1:0] w_hlen;
  logic [WIDTH-1:0] w_llen;

  assign w_edge    = TRIG & ~r_trig_d;
  assign w_end     = CE && (r_cnt == r_len - WIDTH'(1));
  assign w_hlen    = (HIGH_COUNT == '0) ? WIDTH'(1) : HIGH_COUNT;
  assign w_llen    = (LOW_COUNT == '0) ? WIDTH'(1) : LOW_COUNT;
  assign OUT       = r_out;
  assign CYCLE_END = r_cycle_end;

  // trig_d resets high so a TRIG held through reset is not seen as an edge
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_len       <= '0;
      r_trig_d    <= 1'b1;
      r_out       <= 1'b0;
      r_cycle_end <= 1'b0;
    end else begin
      r_trig_d    <= TRIG;
      r_cycle_end <= 1'b0;
      if (!ENABLE) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_out   <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (!MODE || w_edge) begin
            r_state <= HIGH;
            r_cnt   <= '0;
            r_len   <= w_hlen;
            r_out   <= 1'b1;
          end
          HIGH: if (MODE && RETRIGGER && w_edge) r_cnt <= '0;
          else if (w_end) begin
            r_cnt <= '0;
            r_out <= 1'b0;
            if (!MODE || LOW_COUNT != '0) begin
              r_state <= LOW;
              r_len   <= w_llen;
            end else begin
              r_state     <= IDLE;
              r_cycle_end <= 1'b1;
            end
          end else if (CE) r_cnt <= r_cnt + WIDTH'(1);
          LOW: if (w_end) begin
            r_cnt       <= '0;
            r_cycle_end <= 1'b1;
            if (MODE) r_state <= IDLE;
            else begin
              r_state <= HIGH;
              r_len   <= w_hlen;
              r_out   <= 1'b1;
            end
          end else if (CE) r_cnt <= r_cnt + WIDTH'(1);
          default: begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_out   <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_timer_555.sv
// tb_timer_555: directed and random stimulus on non-retriggering and retriggering
// timers, checked each cycle against a remaining-ticks reference model.
module tb_timer_555;
  logic        CLK = 1'b0, RESET_N = 1'b0, CE = 1'b0, ENABLE = 1'b0, MODE = 1'b0, TRIG = 1'b0;
  logic [15:0] HIGH_COUNT = '0, LOW_COUNT = '0;
  logic        out0, cend0, out1, cend1;
  int          n_chk = 0, n_fail = 0;
  int          m_ph[2], m_rem[2], m_len[2];
  bit          m_tp[2], m_out[2], m_cend[2];
  int          hi0, hi1, ce0, ce1;

  always #5 CLK = ~CLK;

  timer_555 #(.WIDTH(16), .RETRIGGER(1'b0)) dut0 (
    .CLK(CLK), .RESET_N(RESET_N), .CE(CE), .ENABLE(ENABLE), .MODE(MODE), .TRIG(TRIG),
    .HIGH_COUNT(HIGH_COUNT), .LOW_COUNT(LOW_COUNT), .OUT(out0), .CYCLE_END(cend0));
  timer_555 #(.WIDTH(16), .RETRIGGER(1'b1)) dut1 (
    .CLK(CLK), .RESET_N(RESET_N), .CE(CE), .ENABLE(ENABLE), .MODE(MODE), .TRIG(TRIG),
    .HIGH_COUNT(HIGH_COUNT), .LOW_COUNT(LOW_COUNT), .OUT(out1), .CYCLE_END(cend1));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, act, exp);
    end
  endtask

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = 0; m_rem[k] = 0; m_len[k] = 0; m_tp[k] = 1'b1; m_out[k] = 1'b0; m_cend[k] = 1'b0;
    end
  endtask

  // phase 0 = idle, 1 = high, 2 = low; m_rem counts CE ticks still owed to the phase
  task automatic mstep(input int k, input bit rt);
    bit e;
    int h, l;
    e = TRIG && !m_tp[k];
    m_tp[k] = TRIG;
    m_cend[k] = 1'b0;
    h = (HIGH_COUNT == 0) ? 1 : int'(HIGH_COUNT);
    l = (LOW_COUNT == 0) ? 1 : int'(LOW_COUNT);
    if (!ENABLE) m_ph[k] = 0;
    else if (m_ph[k] == 0) begin
      if (!MODE || e) begin m_ph[k] = 1; m_len[k] = h; m_rem[k] = h; end
    end else if (m_ph[k] == 1) begin
      if (rt && MODE && e) m_rem[k] = m_len[k];
      else if (CE && m_rem[k] == 1) begin
        if (!MODE || LOW_COUNT != 0) begin m_ph[k] = 2; m_rem[k] = l; end
        else begin m_ph[k] = 0; m_cend[k] = 1'b1; end
      end else if (CE) m_rem[k]--;
    end else if (CE && m_rem[k] == 1) begin
      m_cend[k] = 1'b1;
      if (MODE) m_ph[k] = 0;
      else begin m_ph[k] = 1; m_len[k] = h; m_rem[k] = h; end
    end else if (CE) m_rem[k]--;
    m_out[k] = (m_ph[k] == 1);
  endtask

  task automatic cyc();
    @(posedge CLK);
    if (!RESET_N) mreset();
    else begin mstep(0, 1'b0); mstep(1, 1'b1); end
    #1;
    chk("out0", 32'(out0), 32'(m_out[0]));
    chk("cend0", 32'(cend0), 32'(m_cend[0]));
    chk("out1", 32'(out1), 32'(m_out[1]));
    chk("cend1", 32'(cend1), 32'(m_cend[1]));
    hi0 += int'(out0); hi1 += int'(out1); ce0 += int'(cend0); ce1 += int'(cend1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic setup(input bit mode, input int h, input int l);
    ENABLE = 1'b0; CE = 1'b1; TRIG = 1'b0; MODE = mode;
    HIGH_COUNT = 16'(h); LOW_COUNT = 16'(l);
    run(2);
    hi0 = 0; hi1 = 0; ce0 = 0; ce1 = 0;
  endtask

  initial begin
    mreset();
    TRIG = 1'b1; MODE = 1'b1; ENABLE = 1'b1; CE = 1'b1; HIGH_COUNT = 16'd4; LOW_COUNT = 16'd3;
    #2;
    chk("rst_out", 32'(out0), 32'd0);
    chk("rst_cend", 32'(cend0), 32'd0);
    run(3);
    RESET_N = 1'b1;
    run(4);
    chk("held_trig_no_fire", 32'(out0 | out1), 32'd0);

    setup(1'b0, 3, 2);
    ENABLE = 1'b1;
    run(20);
    chk("ast_high_cycles", 32'(hi0), 32'd12);
    chk("ast_cycle_ends", 32'(ce0), 32'd3);

    setup(1'b0, 0, 0);
    ENABLE = 1'b1;
    run(10);
    chk("zero_high_cycles", 32'(hi0), 32'd5);
    chk("zero_cycle_ends", 32'(ce0), 32'd4);

    setup(1'b1, 4, 3);
    ENABLE = 1'b1;
    run(3);
    hi0 = 0; hi1 = 0; ce0 = 0; ce1 = 0;
    TRIG = 1'b1; cyc();
    TRIG = 1'b0; cyc(); cyc();
    TRIG = 1'b1; cyc();
    TRIG = 1'b0; run(16);
    chk("mono_high_cycles", 32'(hi0), 32'd4);
    chk("retrig_high_cycles", 32'(hi1), 32'd7);
    chk("mono_cycle_ends", 32'(ce0 + ce1), 32'd2);

    setup(1'b0, 5, 5);
    ENABLE = 1'b1;
    run(2);
    ENABLE = 1'b0;
    cyc();
    chk("abort_out", 32'(out0), 32'd0);
    ENABLE = 1'b1;
    hi0 = 0;
    run(5);
    chk("reenable_full_high", 32'(hi0), 32'd5);

    setup(1'b0, 2, 1);
    ENABLE = 1'b1;
    for (int i = 0; i < 24; i++) begin CE = ~CE; cyc(); end

    setup(1'b1, 3, 0);
    ENABLE = 1'b1;
    TRIG = 1'b1; cyc();
    TRIG = 1'b0; HIGH_COUNT = 16'd9; run(8);
    chk("mono_l0_high_cycles", 32'(hi0), 32'd3);

    ENABLE = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      CE = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) TRIG = ~TRIG;
      ENABLE = ENABLE ? ($urandom_range(0, 79) != 0) : ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) MODE = ~MODE;
      if ($urandom_range(0, 19) == 0) HIGH_COUNT = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 19) == 0) LOW_COUNT = 16'($urandom_range(0, 5));
      RESET_N = ($urandom_range(0, 999) != 0);
      cyc();
      RESET_N = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
